pe_col_drain: RTL and testbench

- Bottom-edge collector for one systolic-array column.
- Receives the 48-bit words shifted out of the last PE's bottom port:
  - int8 matmul partial-sum drains (mode 00);
  - fp-mul / fp-add stage results (modes 10 / 11).
- Tags each word and buffers it in a small FIFO, then presents it to the writeback/output buffer over a valid/ready handshake.
- The array cannot stall, so the block reports almost-full back to the array controller and flags overflow.

---
 rtl/tata_drain_pkg.sv | 37 +++
 rtl/drain_fifo.sv | 50 +++++
 rtl/pe_col_drain.sv | 151 +++++++++++++++
 tb/tb_pe_col_drain.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tata_drain_pkg.sv
// Shared types and constants for the systolic-column drain collector.
// Holds the capture modes, FSM states, FIFO entry layout and the int32 saturation helper.
package tata_drain_pkg;

    localparam int TATA_NUM_ROWS = 8;
    localparam int TATA_DATA_W   = 48;
    localparam int ENTRY_ROW_W   = $clog2(TATA_NUM_ROWS);

    typedef enum logic [1:0] {
        MODE_MM    = 2'b00,
        MODE_FPMUL = 2'b10,
        MODE_FPADD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MM_DRAIN  = 2'd1,
        ST_FP_STREAM = 2'd2
    } drain_state_t;

    typedef struct packed {
        mode_t                   mode;
        logic [ENTRY_ROW_W-1:0]  row;
        logic                    last;
        logic [TATA_DATA_W-1:0]  data;
    } drain_entry_t;

    localparam logic [TATA_DATA_W-1:0] SAT_POS = 48'h0000_7FFF_FFFF;
    localparam logic [TATA_DATA_W-1:0] SAT_NEG = 48'hFFFF_8000_0000;

    // In range when every bit above bit 31 repeats the int32 sign bit.
    function automatic logic [TATA_DATA_W-1:0] sat_s32(input logic [TATA_DATA_W-1:0] v);
        if (v[TATA_DATA_W-1:31] == {(TATA_DATA_W-31){v[31]}}) return v;
        return v[TATA_DATA_W-1] ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous first-word-visible FIFO with occupancy count and drop flag.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module drain_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 16,
    parameter int  AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  T            push_data,
    input  logic        pop,
    output T            head,
    output logic [AW:0] count,
    output logic        dropped
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;

    assign push_ok = push && ((count != FULL) || pop);
    assign dropped = push && !push_ok;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// Bottom-edge collector for one systolic column: tags drained words, buffers them, hands them off.
// Define TATA_DRAIN_SAT_EN to saturate matmul words to int32 (sign-extended) at FIFO read.
module pe_col_drain
    import tata_drain_pkg::*;
#(
    parameter int NUM_ROWS   = TATA_NUM_ROWS,
    parameter int DATA_WIDTH = TATA_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_LVL  = 8,
    parameter int ROW_W      = $clog2(NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode_sel_in,
    input  logic                  drain_start,
    input  logic                  fp_start,
    input  logic                  fp_stop,
    input  logic                  col_valid_in,
    input  logic [DATA_WIDTH-1:0] col_in,
    input  logic                  err_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  out_last,
    output logic [1:0]            out_mode,
    output logic                  fifo_afull,
    output logic                  busy,
    output logic                  ovf_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t          state, state_nxt;
    mode_t                 mode_q, mode_nxt;
    logic [ROW_W-1:0]      row_cnt, row_nxt;
    logic                  cap, cap_last, idle_drop;
    drain_entry_t          cap_entry, st_entry, head;
    logic                  st_valid;
    logic [CNT_W-1:0]      count;
    logic                  pop, fifo_drop;
    logic [DATA_WIDTH-1:0] data_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_MM;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mode_q  <= mode_nxt;
            row_cnt <= row_nxt;
        end
    end

    // Rows leave bottom-first, so the counter runs NUM_ROWS-1 down to 0.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        row_nxt   = row_cnt;
        cap       = 1'b0;
        cap_last  = 1'b0;
        idle_drop = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idle_drop = col_valid_in;
                if (drain_start && (mode_sel_in == 2'b00)) begin
                    state_nxt = ST_MM_DRAIN;
                    mode_nxt  = MODE_MM;
                    row_nxt   = ROW_W'(NUM_ROWS - 1);
                end else if (fp_start && mode_sel_in[1]) begin
                    state_nxt = ST_FP_STREAM;
                    mode_nxt  = mode_sel_in[0] ? MODE_FPADD : MODE_FPMUL;
                end
            end
            ST_MM_DRAIN: begin
                if (col_valid_in) begin
                    cap = 1'b1;
                    if (row_cnt == '0) begin
                        cap_last  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        row_nxt = row_cnt - ROW_W'(1);
                    end
                end
            end
            ST_FP_STREAM: begin
                cap = col_valid_in;
                if (fp_stop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_entry      = '0;
        cap_entry.mode = mode_q;
        cap_entry.row  = (state == ST_MM_DRAIN) ? ENTRY_ROW_W'(row_cnt) : '0;
        cap_entry.last = cap_last;
        cap_entry.data = TATA_DATA_W'(col_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= 1'b0;
            st_entry <= '0;
        end else begin
            st_valid <= cap;
            st_entry <= cap_entry;
        end
    end

    drain_fifo #(
        .T     (drain_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_valid),
        .push_data (st_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .dropped   (fifo_drop)
    );

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_afull = (count >= CNT_W'(AFULL_LVL));
    assign busy       = (state != ST_IDLE);

    always_comb begin
        data_sel = head.data[DATA_WIDTH-1:0];
`ifdef TATA_DRAIN_SAT_EN
        if (head.mode == MODE_MM) data_sel = DATA_WIDTH'(sat_s32(head.data));
`endif
    end

    // Gate with out_valid so stale memory never shows on the port.
    assign out_data = out_valid ? data_sel : '0;
    assign out_row  = out_valid ? head.row[ROW_W-1:0] : '0;
    assign out_last = out_valid && head.last;
    assign out_mode = out_valid ? head.mode : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         ovf_err <= 1'b0;
        else if (idle_drop || fifo_drop) ovf_err <= 1'b1;
        else if (err_clr)                ovf_err <= 1'b0;
    end

endmodule

// File: tb/tb_pe_col_drain.sv
// Directed self-checking bench for pe_col_drain (default parameters: 8 rows, 16-entry FIFO).
module tb_pe_col_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_sel_in = 2'b00;
    logic        drain_start = 1'b0;
    logic        fp_start = 1'b0;
    logic        fp_stop = 1'b0;
    logic        col_valid_in = 1'b0;
    logic [47:0] col_in = '0;
    logic        err_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_data;
    logic [2:0]  out_row;
    logic        out_last;
    logic [1:0]  out_mode;
    logic        fifo_afull;
    logic        busy;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    pe_col_drain dut (
        .clk          (clk),
        .rst          (rst),
        .mode_sel_in  (mode_sel_in),
        .drain_start  (drain_start),
        .fp_start     (fp_start),
        .fp_stop      (fp_stop),
        .col_valid_in (col_valid_in),
        .col_in       (col_in),
        .err_clr      (err_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_last     (out_last),
        .out_mode     (out_mode),
        .fifo_afull   (fifo_afull),
        .busy         (busy),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drain_start  = 1'b0;
        fp_start     = 1'b0;
        fp_stop      = 1'b0;
        col_valid_in = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; col_valid_in = 1'b1; col_in = 48'h123; out_ready = 1'b1; drain_start = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_valid, out_data, out_row, out_last, out_mode, fifo_afull, busy, ovf_err} !== 58'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h busy=%b ovf=%b exp all zero",
                     out_valid, out_data, busy, ovf_err);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, out_valid, ovf_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got busy/valid/ovf=%b exp 000", {busy, out_valid, ovf_err});
        end
    endtask

    task automatic test_matmul();
        logic [47:0] w [8];
        w = '{48'd10, 48'd20, 48'hFFFF_FFFF_FFFB, 48'h0000_7FFF_FFFF,
              48'd0, 48'd1, 48'h0000_1234_5678, 48'hFFFF_FFFF_FFFF};
        out_ready = 1'b1; mode_sel_in = 2'b00; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mm_busy_start got %b exp 1", busy); end
        for (int k = 0; k <= 8; k++) begin
            col_valid_in = (k < 8);
            col_in = (k < 8) ? w[k] : 48'd0;
            tick();
            checks++;
            if (busy !== (k < 7)) begin
                errors++; $display("FAIL mm_busy k=%0d got %b exp %b", k, busy, (k < 7));
            end
            checks++;
            if (k == 0) begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL mm_latency got out_valid=%b exp 0", out_valid);
                end
            end else begin
                if ({out_valid, out_data, out_row, out_last, out_mode} !==
                    {1'b1, w[k-1], 3'(8 - k), (k == 8), 2'b00}) begin
                    errors++;
                    $display("FAIL mm_word k=%0d got v=%b d=%h r=%0d l=%b m=%b exp d=%h r=%0d l=%b",
                             k, out_valid, out_data, out_row, out_last, out_mode, w[k-1], 8 - k, (k == 8));
                end
            end
        end
        col_valid_in = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mm_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        int n;
        logic [47:0] held;
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mode_sel_in = 2'b00; drain_start = 1'b1;
            tick();
            drain_start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                col_valid_in = 1'b1; col_in = 48'(100 * (d + 1) + k);
                tick();
                if (d == 0 && k == 7) begin
                    checks++;
                    if (fifo_afull !== 1'b0) begin errors++; $display("FAIL afull_at7 got %b exp 0", fifo_afull); end
                end
            end
            col_valid_in = 1'b0;
            tick();
            if (d == 0) begin
                checks++;
                if (fifo_afull !== 1'b1) begin errors++; $display("FAIL afull_at8 got %b exp 1", fifo_afull); end
            end
        end
        held = out_data;
        tick();
        checks++;
        if ({out_valid, out_data, out_row, ovf_err} !== {1'b1, 48'd100, 3'd7, 1'b0} || held !== 48'd100) begin
            errors++;
            $display("FAIL full_hold got v=%b d=%h held=%h r=%0d ovf=%b exp d=64 r=7 ovf=0",
                     out_valid, out_data, held, out_row, ovf_err);
        end
        mode_sel_in = 2'b10; fp_start = 1'b1;
        tick();
        fp_start = 1'b0;
        col_valid_in = 1'b1; col_in = 48'h0000_0000_DEAD;
        tick();
        col_valid_in = 1'b0; fp_stop = 1'b1;
        tick();
        fp_stop = 1'b0;
        checks++;
        if ({ovf_err, busy} !== 2'b10) begin
            errors++; $display("FAIL ovf_set got ovf/busy=%b exp 10", {ovf_err, busy});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({ovf_err, fifo_afull} !== 2'b01) begin
            errors++; $display("FAIL ovf_clear got ovf/afull=%b exp 01", {ovf_err, fifo_afull});
        end
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 40) begin
            checks++;
            if (out_data !== ((n < 8) ? 48'(100 + n) : 48'(200 + n - 8)) || out_mode !== 2'b00) begin
                errors++; $display("FAIL ovf_drain n=%0d got d=%h m=%b", n, out_data, out_mode);
            end
            n++;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (n !== 16) begin errors++; $display("FAIL ovf_count got %0d exp 16", n); end
        col_valid_in = 1'b1; err_clr = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL idle_drop_set_wins got %b exp 1", ovf_err); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_drop_fifo got %b exp 0", out_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL idle_drop_clear got %b exp 0", ovf_err); end
    endtask

    task automatic test_fp_stream();
        logic [47:0] w1, w2;
        w1 = {22'd0, 8'h85, 18'h12345};
        w2 = 48'h8000_0000_0001;
        out_ready = 1'b1; mode_sel_in = 2'b01; fp_start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fp_mode01_ignored got busy=%b exp 0", busy); end
        mode_sel_in = 2'b10;
        tick();
        fp_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fp_start got busy=%b exp 1", busy); end
        col_valid_in = 1'b1; col_in = w1; mode_sel_in = 2'b00; drain_start = 1'b1;
        tick();
        drain_start = 1'b0; fp_stop = 1'b1; col_in = w2;
        tick();
        idle_inputs();
        checks++;
        if ({busy, out_valid, out_data, out_row, out_last, out_mode} !== {1'b0, 1'b1, w1, 3'd0, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL fp_word1 got b=%b v=%b d=%h r=%0d l=%b m=%b exp b=0 d=%h m=10",
                     busy, out_valid, out_data, out_row, out_last, out_mode, w1);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_row, out_last, out_mode} !== {1'b1, w2, 3'd0, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL fp_stop_word got v=%b d=%h m=%b exp d=%h m=10", out_valid, out_data, out_mode, w2);
        end
        tick();
        checks++;
        if ({out_valid, ovf_err} !== 2'b00) begin
            errors++; $display("FAIL fp_end got valid/ovf=%b exp 00", {out_valid, ovf_err});
        end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0; mode_sel_in = 2'b00; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            col_valid_in = 1'b1; col_in = 48'(50 + k);
            tick();
        end
        col_valid_in = 1'b0;
        repeat (2) tick();
        checks++;
        if ({out_valid, busy} !== 2'b11) begin
            errors++; $display("FAIL mid_pre got valid/busy=%b exp 11", {out_valid, busy});
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({out_valid, busy, fifo_afull} !== 3'b000) begin
            errors++; $display("FAIL mid_reset got valid/busy/afull=%b exp 000", {out_valid, busy, fifo_afull});
        end
        tick();
        rst = 1'b0;
        tick();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0; col_valid_in = 1'b1; col_in = 48'h77;
        tick();
        col_valid_in = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_data, out_row, busy} !== {1'b1, 48'h77, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL mid_restart got v=%b d=%h r=%0d b=%b exp d=77 r=7 b=1", out_valid, out_data, out_row, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [47:0] w [8];
        logic [47:0] e [8];
        w = '{48'h0001_0000_0000, 48'hFF00_0000_0000, 48'hFFFF_8000_0000, 48'h0000_8000_0000,
              48'd3, 48'd4, 48'd5, 48'd6};
`ifdef TATA_DRAIN_SAT_EN
        e = '{48'h0000_7FFF_FFFF, 48'hFFFF_8000_0000, 48'hFFFF_8000_0000, 48'h0000_7FFF_FFFF,
              48'd3, 48'd4, 48'd5, 48'd6};
`else
        e = w;
`endif
        out_ready = 1'b0; mode_sel_in = 2'b00; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            col_valid_in = 1'b1; col_in = w[k];
            tick();
        end
        col_valid_in = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({out_valid, out_data, out_row} !== {1'b1, e[k], 3'(7 - k)}) begin
                errors++;
                $display("FAIL sat_word k=%0d got v=%b d=%h r=%0d exp d=%h r=%0d", k, out_valid, out_data, out_row, e[k], 7 - k);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        mode_sel_in = 2'b11; fp_start = 1'b1;
        tick();
        fp_start = 1'b0; col_valid_in = 1'b1; col_in = 48'h0001_0000_0000; fp_stop = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({out_valid, out_data, out_mode} !== {1'b1, 48'h0001_0000_0000, 2'b11}) begin
            errors++; $display("FAIL sat_fp_raw got v=%b d=%h m=%b exp d=000100000000 m=11", out_valid, out_data, out_mode);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_overflow();
        test_fp_stream();
        test_reset_mid_drain();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
